// File: rtl/umi_packet_merge_multi.sv
// umi_packet_merge_multi
//   Coalesces back-to-back contiguous narrow UMI packets (<= IDW bits) into a
//   single wide packet of up to ODW bits (ODW = K*IDW, K >= 2).
//
//   State machine:
//     EMPTY - nothing held. Any valid input is loaded.
//     ACCUM - partial packet held. Matching inputs are absorbed.
//     FULL  - merged packet is presented on the output. An input can be
//             loaded in the same cycle the output drains.
//
//   Optional feature (macro UMI_MERGE_TIMEOUT_EN): an idle counter pushes
//   ACCUM to FULL after TIMEOUT consecutive cycles without an absorb.
//
//   Command layout used for matching:
//     [4:0] opcode  [7:5] size  [15:8] len  [19:16] qos  [21:20] prot
//     [22] eom      [23] eof    [24] ex     [26:25] user/err  [31:27] hostid
//   Any bits above 31 (CW > 32) are treated like hostid and must also match.
//
//   Ports:
//     clk, reset (async, active-high), flush (level; forces ACCUM -> FULL)
//     umi_in_*   narrow input channel  (valid/ready, cmd, dstaddr, srcaddr, data)
//     umi_out_*  wide output channel   (valid/ready, cmd, dstaddr, srcaddr, data)
//     busy       accumulator non-empty (state != EMPTY)
module umi_packet_merge_multi #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int IDW     = 64,
  parameter int ODW     = 256,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           umi_in_valid,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_in_ready,
  output logic           umi_out_valid,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  input  logic           umi_out_ready,
  output logic           busy
);

  localparam int OB   = ODW / 8;
  localparam int IB   = IDW / 8;
  localparam int CNTW = $clog2(OB) + 1;
  // Wide enough for the largest encodable packet: (1<<7)*256 bytes.
  localparam int BW   = 17;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if ((ODW % IDW) != 0 || (ODW / IDW) < 2 || IDW < 8 || TIMEOUT < 1 || CW < 32)
  begin : g_bad_cfg
    $error("umi_packet_merge_multi: illegal parameter combination");
  end

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   src_q, src_d;
  logic [ODW-1:0]  data_q, data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic [4:0]    in_op;
  logic [2:0]    in_size;
  logic [7:0]    in_len;
  logic          in_eom;
  logic          in_ex;
  logic [BW-1:0] in_bytes;
  logic [BW-1:0] sum_bytes;
  logic          in_mergeable;

  assign in_op     = umi_in_cmd[4:0];
  assign in_size   = umi_in_cmd[7:5];
  assign in_len    = umi_in_cmd[15:8];
  assign in_eom    = umi_in_cmd[22];
  assign in_ex     = umi_in_cmd[24];
  assign in_bytes  = ({{(BW-8){1'b0}}, in_len} + BW'(1)) << in_size;
  assign sum_bytes = BW'(cnt_q) + in_bytes;

  // read, write, write_posted, rdma, read_resp, write_resp; no exclusives
  assign in_mergeable = ~in_ex &
                        ((in_op == 5'h01) | (in_op == 5'h03) | (in_op == 5'h05) |
                         (in_op == 5'h07) | (in_op == 5'h02) | (in_op == 5'h04));

  // ---------------------------------------------------------------------------
  // Merge match against the accumulator. Everything but len and eom must be
  // identical; addresses must continue exactly where the accumulator ends.
  // ---------------------------------------------------------------------------
  logic fields_eq, addr_eq, fits, len_ok, match;

  assign fields_eq = (umi_in_cmd[CW-1:23] == cmd_q[CW-1:23]) &
                     (umi_in_cmd[21:16]   == cmd_q[21:16]) &
                     (umi_in_cmd[7:0]     == cmd_q[7:0]);
  assign addr_eq   = (umi_in_dstaddr == dst_q + AW'(cnt_q)) &
                     (umi_in_srcaddr == src_q + AW'(cnt_q));
  assign fits      = sum_bytes <= BW'(OB);
  // merged len field is 8 bits, so at most 256 beats of the common size
  assign len_ok    = (sum_bytes >> in_size) <= BW'(256);
  assign match     = fields_eq & addr_eq & ~cmd_q[22] & fits & len_ok;

  // ---------------------------------------------------------------------------
  // Input data: drop bytes beyond B so unused output bytes stay zero, then
  // widen and shift to the current byte offset.
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] in_data_m;
  logic [ODW-1:0] in_wide, in_shift;

  always_comb begin
    in_data_m = '0;
    for (int i = 0; i < IB; i++) begin
      if (BW'(i) < in_bytes) in_data_m[i*8 +: 8] = umi_in_data[i*8 +: 8];
    end
  end

  assign in_wide  = {{(ODW-IDW){1'b0}}, in_data_m};
  assign in_shift = in_wide << {cnt_q, 3'b000};

  // ---------------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------------
  logic absorb;
  logic timeout_hit;

`ifdef UMI_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;

  assign timeout_hit = (idle_q == TW'(TIMEOUT));

  always_comb begin
    idle_d = '0;
    if (state_q == ST_ACCUM && !absorb)
      idle_d = timeout_hit ? idle_q : idle_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic in_ready_c;
  logic load;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dst_d      = dst_q;
    src_d      = src_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    absorb     = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        in_ready_c = 1'b1;
        load       = umi_in_valid;
      end
      ST_ACCUM: begin
        in_ready_c = umi_in_valid & match & ~flush;
        absorb     = in_ready_c;
        // a non-matching input stalls until the current packet has drained
        if (!absorb && (umi_in_valid || flush || timeout_hit)) state_d = ST_FULL;
      end
      ST_FULL: begin
        in_ready_c = umi_out_ready;
        if (umi_out_ready) begin
          if (umi_in_valid) begin
            load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
            cmd_d   = '0;
            dst_d   = '0;
            src_d   = '0;
            data_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      cmd_d   = umi_in_cmd;
      dst_d   = umi_in_dstaddr;
      src_d   = umi_in_srcaddr;
      data_d  = in_wide;
      cnt_d   = CNTW'(in_bytes);
      state_d = (in_eom || !in_mergeable || in_bytes == BW'(OB)) ? ST_FULL : ST_ACCUM;
    end

    if (absorb) begin
      data_d        = data_q | in_shift;
      cnt_d         = CNTW'(sum_bytes);
      cmd_d[15:8]   = 8'((sum_bytes >> in_size) - BW'(1));
      cmd_d[22]     = in_eom;
      state_d       = (in_eom || sum_bytes == BW'(OB)) ? ST_FULL : ST_ACCUM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from state registers.
  // ---------------------------------------------------------------------------
  assign umi_in_ready    = in_ready_c & ~reset;
  assign umi_out_valid   = (state_q == ST_FULL);
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;
  assign umi_out_data    = data_q;
  assign busy            = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_umi_packet_merge_multi.sv
// Bench for umi_packet_merge_multi (IDW=64, ODW=256, TIMEOUT=16).
// Accepted inputs feed a transaction-level grouping model; every output
// handshake is compared against the next group the model closed.
module tb_umi_packet_merge_multi;
  localparam int CW = 32, AW = 64, IDW = 64, ODW = 256, OB = 32;

  logic           clk = 1'b0;
  logic           reset, flush;
  logic           umi_in_valid, umi_in_ready;
  logic [CW-1:0]  umi_in_cmd;
  logic [AW-1:0]  umi_in_dstaddr, umi_in_srcaddr;
  logic [IDW-1:0] umi_in_data;
  logic           umi_out_valid, umi_out_ready, busy;
  logic [CW-1:0]  umi_out_cmd;
  logic [AW-1:0]  umi_out_dstaddr, umi_out_srcaddr;
  logic [ODW-1:0] umi_out_data;

  umi_packet_merge_multi #(.CW(CW), .AW(AW), .IDW(IDW), .ODW(ODW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
    .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
    .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] cmd; logic [63:0] dst, src, data; } pkt_t;
  typedef struct { logic [31:0] cmd; logic [63:0] dst, src; logic [255:0] data; } out_t;

  pkt_t txq[$];
  out_t expq[$], gotq[$];

  int n_cmp = 0, n_err = 0;
  int vld_pct = 100, rdy_pct = 100, flush_pct = 0, stalls = 0, lat;
  bit force_flush = 0, cur_vld = 0, hold_v = 0, saw_out;
  out_t held;

  // model: currently open group
  bit          g_open = 0;
  logic [31:0] g_cmd;
  logic [63:0] g_dst, g_src;
  int          g_cnt;
  logic [7:0]  g_bytes [OB];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_cmd(int op, int sz, int ln, bit eom, bit ex, int qos);
    logic [31:0] c;
    c = '0;
    c[4:0] = op[4:0]; c[7:5] = sz[2:0]; c[15:8] = ln[7:0];
    c[19:16] = qos[3:0]; c[22] = eom; c[24] = ex;
    return c;
  endfunction

  function automatic int nbytes(logic [31:0] c);
    return (1 << c[7:5]) * (int'(c[15:8]) + 1);
  endfunction

  function automatic bit merge_op(logic [31:0] c);
    return (c[4:0] inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7}) && !c[24];
  endfunction

  task automatic model_close();
    out_t o;
    if (!g_open) return;
    o.cmd = g_cmd;
    o.cmd[15:8] = 8'((g_cnt >> g_cmd[7:5]) - 1);
    o.dst = g_dst; o.src = g_src; o.data = '0;
    for (int i = 0; i < g_cnt; i++) o.data[i*8 +: 8] = g_bytes[i];
    expq.push_back(o);
    g_open = 0;
  endtask

  task automatic model_add(pkt_t p, int b);
    for (int i = 0; i < b && g_cnt + i < OB; i++) g_bytes[g_cnt + i] = p.data[i*8 +: 8];
    g_cnt += b;
    g_cmd[22] = p.cmd[22];
  endtask

  task automatic model_accept(pkt_t p);
    int b;
    bit m;
    b = nbytes(p.cmd);
    m = g_open && p.cmd[7:0] == g_cmd[7:0] && p.cmd[21:16] == g_cmd[21:16] &&
        p.cmd[31:23] == g_cmd[31:23] && !g_cmd[22] &&
        p.dst == g_dst + 64'(g_cnt) && p.src == g_src + 64'(g_cnt) &&
        g_cnt + b <= OB && ((g_cnt + b) >> p.cmd[7:5]) <= 256;
    if (m) begin
      model_add(p, b);
      if (p.cmd[22] || g_cnt == OB) model_close();
    end else begin
      model_close();
      g_open = 1; g_cmd = p.cmd; g_dst = p.dst; g_src = p.src; g_cnt = 0;
      model_add(p, b);
      if (p.cmd[22] || !merge_op(p.cmd) || b == OB) model_close();
    end
  endtask

  task automatic check_out();
    out_t o, e;
    o.cmd = umi_out_cmd; o.dst = umi_out_dstaddr; o.src = umi_out_srcaddr; o.data = umi_out_data;
    gotq.push_back(o);
    if (expq.size() == 0) begin
      chk("out_unexpected", 1, 0);
    end else begin
      e = expq.pop_front();
      chk("out_cmd", o.cmd, e.cmd);
      chk("out_dst", o.dst, e.dst);
      chk("out_src", o.src, e.src);
      chk("out_data", o.data, e.data);
    end
  endtask

  // One cycle: drive at negedge, sample 3ns later, return at next negedge.
  task automatic step();
    if (!cur_vld && txq.size() > 0 && $urandom_range(99) < vld_pct) cur_vld = 1;
    umi_in_valid = cur_vld;
    if (cur_vld) begin
      umi_in_cmd = txq[0].cmd; umi_in_dstaddr = txq[0].dst;
      umi_in_srcaddr = txq[0].src; umi_in_data = txq[0].data;
    end else begin
      umi_in_cmd = '0; umi_in_dstaddr = '0; umi_in_srcaddr = '0; umi_in_data = '0;
    end
    umi_out_ready = ($urandom_range(99) < rdy_pct);
    flush = force_flush || ($urandom_range(99) < flush_pct);
    #3;
    if (hold_v) begin
      chk("hold_valid", umi_out_valid, 1);
      chk("hold_cmd", umi_out_cmd, held.cmd);
      chk("hold_dst", umi_out_dstaddr, held.dst);
      chk("hold_data", umi_out_data, held.data);
    end
    if (umi_in_valid && !umi_in_ready) stalls++;
    if (flush) model_close();
    if (umi_in_valid && umi_in_ready) begin
      model_accept(txq.pop_front());
      cur_vld = 0;
    end
    if (umi_out_valid && umi_out_ready) check_out();
    hold_v = umi_out_valid && !umi_out_ready;
    if (hold_v) begin
      held.cmd = umi_out_cmd; held.dst = umi_out_dstaddr; held.data = umi_out_data;
    end
    @(negedge clk);
  endtask

  task automatic drain(int max);
    for (int c = 0; c < max; c++) begin
      if (txq.size() == 0 && !cur_vld && expq.size() == 0 && !g_open && !umi_out_valid && !busy) begin
        force_flush = 0;
        return;
      end
      force_flush = (txq.size() == 0 && !cur_vld);
      step();
    end
    force_flush = 0;
    chk("drain_timeout", 0, 1);
  endtask

  task automatic push_wr(logic [63:0] dst, bit eom, logic [63:0] data);
    txq.push_back('{mk_cmd(5, 3, 0, eom, 0, 0), dst, dst + 64'h1000, data});
  endtask

  task automatic gen_random(int n);
    logic [31:0] c;
    logic [63:0] d, s, nd, ns;
    bit have;
    int op, sz, ln, sel;
    have = 0; c = '0; nd = '0; ns = '0;
    for (int k = 0; k < n; k++) begin
      if (have && $urandom_range(99) < 75) begin
        c[22] = ($urandom_range(99) < 15);
        d = nd;
        s = ($urandom_range(99) < 4) ? ns + 64'd8 : ns;
      end else begin
        sel = $urandom_range(9);
        case (sel)
          4: op = 3; 5: op = 1; 6: op = 2; 7: op = 4; 8: op = 7; 9: op = 9;
          default: op = 5;
        endcase
        case ($urandom_range(4))
          0: begin sz = 3; ln = 0; end
          1: begin sz = 2; ln = 0; end
          2: begin sz = 2; ln = 1; end
          3: begin sz = 0; ln = 3; end
          default: begin sz = 1; ln = 2; end
        endcase
        c = mk_cmd(op, sz, ln, $urandom_range(99) < 15, $urandom_range(19) == 0,
                   $urandom_range(1));
        d = {32'h0, $urandom} & 64'hffff_ffc0;
        s = {$urandom, $urandom};
        have = 1;
      end
      nd = d + 64'(nbytes(c));
      ns = s + 64'(nbytes(c));
      txq.push_back('{c, d, s, {$urandom, $urandom}});
    end
  endtask

  logic [63:0] dv [5];

  initial begin
    reset = 1; flush = 0; umi_in_valid = 0; umi_in_cmd = '0; umi_in_dstaddr = '0;
    umi_in_srcaddr = '0; umi_in_data = '0; umi_out_ready = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", umi_out_valid, 0);
    chk("rst_in_ready", umi_in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", umi_out_cmd, 0);
    chk("rst_data", umi_out_data, 0);
    @(negedge clk);
    reset = 0;
    #3;
    chk("empty_in_ready", umi_in_ready, 1);
    @(negedge clk);

    // 4 contiguous posted writes, eom on the last -> one 32B packet
    for (int i = 0; i < 5; i++) dv[i] = {$urandom, $urandom};
    gotq.delete();
    for (int i = 0; i < 4; i++) push_wr(64'h100 + 64'(i*8), i == 3, dv[i]);
    drain(100);
    chk("t1_nout", gotq.size(), 1);
    if (gotq.size() > 0) begin
      chk("t1_dst", gotq[0].dst, 64'h100);
      chk("t1_len", gotq[0].cmd[15:8], 3);
      chk("t1_eom", gotq[0].cmd[22], 1);
      chk("t1_data", gotq[0].data, {dv[3], dv[2], dv[1], dv[0]});
    end

    // non-contiguous pair -> two packets, one stall cycle
    gotq.delete(); stalls = 0;
    push_wr(64'h100, 0, dv[0]);
    push_wr(64'h200, 1, dv[1]);
    drain(100);
    chk("t2_stalls", stalls, 1);
    chk("t2_nout", gotq.size(), 2);
    if (gotq.size() == 2) begin
      chk("t2_dst0", gotq[0].dst, 64'h100);
      chk("t2_dst1", gotq[1].dst, 64'h200);
      chk("t2_len1", gotq[1].cmd[15:8], 0);
    end

    // 5 contiguous, no eom: 32B out, 5th reloaded same cycle, flushed later
    gotq.delete(); stalls = 0;
    for (int i = 0; i < 5; i++) push_wr(64'h100 + 64'(i*8), 0, dv[i]);
    drain(100);
    chk("t3_stalls", stalls, 0);
    chk("t3_nout", gotq.size(), 2);
    if (gotq.size() == 2) begin
      chk("t3_len0", gotq[0].cmd[15:8], 3);
      chk("t3_dst1", gotq[1].dst, 64'h120);
      chk("t3_len1", gotq[1].cmd[15:8], 0);
    end

    // backpressure: full packet pending, 10 cycles of out_ready=0
    gotq.delete(); stalls = 0; rdy_pct = 0;
    for (int i = 0; i < 4; i++) push_wr(64'h500 + 64'(i*8), i == 3, dv[i]);
    for (int i = 0; i < 3; i++) push_wr(64'h600 + 64'(i*8), i == 2, dv[i+1]);
    repeat (14) step();
    chk("bp_stalls", stalls, 10);
    rdy_pct = 100;
    drain(100);
    chk("bp_nout", gotq.size(), 2);

    // lone 4B write with no follow-up input
    gotq.delete(); rdy_pct = 0;
    txq.push_back('{mk_cmd(5, 2, 0, 0, 0, 0), 64'h700, 64'h900, dv[4]});
    for (int i = 0; i < 5 && txq.size() > 0; i++) step();
    chk("to_busy", busy, 1);
`ifdef UMI_MERGE_TIMEOUT_EN
    lat = 0;
    while (!umi_out_valid && lat < 40) begin step(); lat++; end
    chk("to_latency", lat, 17);
    model_close();
`else
    saw_out = 0;
    repeat (20) begin step(); if (umi_out_valid) saw_out = 1; end
    chk("to_no_out", saw_out, 0);
    force_flush = 1; step(); force_flush = 0;
    chk("flush_latency", umi_out_valid, 1);
`endif
    rdy_pct = 100;
    drain(100);
    chk("to_nout", gotq.size(), 1);

    // reset while ACCUM holds 16B: accumulator discarded
    gotq.delete();
    push_wr(64'h300, 0, dv[0]);
    push_wr(64'h308, 0, dv[1]);
    for (int i = 0; i < 10 && txq.size() > 0; i++) step();
    chk("mr_busy", busy, 1);
    reset = 1; umi_in_valid = 0;
    #3;
    chk("mr_out_valid", umi_out_valid, 0);
    chk("mr_busy0", busy, 0);
    @(negedge clk);
    reset = 0; g_open = 0; hold_v = 0; cur_vld = 0;
    push_wr(64'h400, 1, dv[2]);
    drain(100);
    chk("mr_nout", gotq.size(), 1);
    if (gotq.size() > 0) begin
      chk("mr_dst", gotq[0].dst, 64'h400);
      chk("mr_len", gotq[0].cmd[15:8], 0);
    end

    // randomized traffic
    vld_pct = 70; rdy_pct = 60; flush_pct = 3;
    gen_random(400);
    drain(6000);
    vld_pct = 100; rdy_pct = 100; flush_pct = 0;
    drain(200);
    chk("end_expq_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
